// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned CNT_W  = 3;
    localparam logic [4:0]  REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        REDIRECT   = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard info / pipeline control bundle between the pipeline (master) and hazard_ctrl (slave).
// Optional HAZARD_PERF_EN adds the stall/flush performance counters.
interface hazard_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_uses_rs2;
    logic [4:0]      ex_rd;
    logic            ex_mem_read;
    logic            ex_branch_taken;
    logic            ex_jal;
    logic            ex_jalr;
    logic [XLEN-1:0] ex_target;
    logic            dmem_req;
    logic            dmem_ready;
    logic            pc_write;
    logic            if_id_write;
    logic            if_id_flush;
    logic            id_flush;
    logic            ex_mem_stall;
    logic            pc_sel;
    logic [XLEN-1:0] pc_target;
`ifdef HAZARD_PERF_EN
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_flush_cnt;
`endif

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_jal, ex_jalr, ex_target, dmem_req, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_flush, ex_mem_stall,
               pc_sel, pc_target
`ifdef HAZARD_PERF_EN
        , input perf_stall_cnt, perf_flush_cnt
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_jal, ex_jalr, ex_target, dmem_req, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_flush, ex_mem_stall,
               pc_sel, pc_target
`ifdef HAZARD_PERF_EN
        , output perf_stall_cnt, perf_flush_cnt
`endif
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational decoder for the three hazard events: load-use, redirect and dmem wait.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_mem_read,
    input  logic       i_ex_branch_taken,
    input  logic       i_ex_jal,
    input  logic       i_ex_jalr,
    input  logic       i_dmem_req,
    input  logic       i_dmem_ready,
    output logic       o_load_use,
    output logic       o_redirect,
    output logic       o_mwait
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = (i_ex_rd == i_id_rs1);
    assign w_rs2_hit  = i_id_uses_rs2 && (i_ex_rd == i_id_rs2);
    assign o_load_use = i_ex_mem_read && (i_ex_rd != REG_X0) && (w_rs1_hit || w_rs2_hit);
    assign o_redirect = i_ex_branch_taken || i_ex_jal || i_ex_jalr;
    assign o_mwait    = i_dmem_req && !i_dmem_ready;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Mealy FSM sequencing load-use stalls, redirect flushes and dmem freezes.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES      = 2,
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned XLEN              = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);

    state_t           r_state;
    state_t           r_ret;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_eff_state;
    state_t           w_next_state;
    state_t           w_next_ret;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_load_use;
    logic             w_redirect;
    logic             w_mwait;

    hazard_detect u_detect (
        .i_id_rs1          (hz.id_rs1),
        .i_id_rs2          (hz.id_rs2),
        .i_id_uses_rs2     (hz.id_uses_rs2),
        .i_ex_rd           (hz.ex_rd),
        .i_ex_mem_read     (hz.ex_mem_read),
        .i_ex_branch_taken (hz.ex_branch_taken),
        .i_ex_jal          (hz.ex_jal),
        .i_ex_jalr         (hz.ex_jalr),
        .i_dmem_req        (hz.dmem_req),
        .i_dmem_ready      (hz.dmem_ready),
        .o_load_use        (w_load_use),
        .o_redirect        (w_redirect),
        .o_mwait           (w_mwait)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_ret   <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ret   <= w_next_ret;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        // The cycle the wait ends, the pipeline advances, so act as the saved state would.
        w_eff_state     = (r_state == MEM_WAIT && !w_mwait) ? r_ret : r_state;
        w_next_state    = r_state;
        w_next_ret      = r_ret;
        w_next_cnt      = r_cnt;
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_flush     = 1'b0;
        hz.ex_mem_stall = 1'b0;
        hz.pc_sel       = 1'b0;
        hz.pc_target    = '0;

        if (w_mwait) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.ex_mem_stall = 1'b1;
            w_next_state    = MEM_WAIT;
            if (r_state != MEM_WAIT) begin
                w_next_ret = r_state;
            end
        end else begin
            w_next_state = w_eff_state;
            unique case (w_eff_state)
                RUN, LOAD_STALL: begin
                    if (w_redirect) begin
                        hz.pc_sel      = 1'b1;
                        hz.pc_target   = hz.ex_target;
                        hz.if_id_flush = 1'b1;
                        hz.id_flush    = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_next_state = REDIRECT;
                            w_next_cnt   = CNT_W'(FLUSH_CYCLES - 1);
                        end else begin
                            w_next_state = RUN;
                            w_next_cnt   = '0;
                        end
                    end else if (w_eff_state == LOAD_STALL) begin
                        hz.pc_write    = 1'b0;
                        hz.if_id_write = 1'b0;
                        hz.id_flush    = 1'b1;
                        if (r_cnt <= CNT_W'(1)) begin
                            w_next_state = RUN;
                            w_next_cnt   = '0;
                        end else begin
                            w_next_cnt = r_cnt - CNT_W'(1);
                        end
                    end else if (w_load_use) begin
                        hz.pc_write    = 1'b0;
                        hz.if_id_write = 1'b0;
                        hz.id_flush    = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            w_next_state = LOAD_STALL;
                            w_next_cnt   = CNT_W'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                REDIRECT: begin
                    hz.if_id_flush = 1'b1;
                    hz.id_flush    = 1'b1;
                    if (r_cnt <= CNT_W'(1)) begin
                        w_next_state = RUN;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_next_state = RUN;
                    w_next_cnt   = '0;
                end
            endcase
        end

        if (!rst_n) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.if_id_flush  = 1'b1;
            hz.id_flush     = 1'b1;
            hz.ex_mem_stall = 1'b0;
            hz.pc_sel       = 1'b0;
            hz.pc_target    = '0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (!hz.pc_write && r_perf_stall != '1) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (hz.id_flush && r_perf_flush != '1) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign hz.perf_stall_cnt = r_perf_stall;
    assign hz.perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: default build (FLUSH=2, LOAD=1) plus a
// second instance (FLUSH=3, LOAD=3) for multi-cycle stall, stall abandonment and mid-stall reset.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    int   total = 0;
    int   bad   = 0;

    localparam logic [5:0] C_RESET  = 6'b001100;
    localparam logic [5:0] C_IDLE   = 6'b110000;
    localparam logic [5:0] C_STALL  = 6'b000100;
    localparam logic [5:0] C_REDIR  = 6'b111101;
    localparam logic [5:0] C_FLUSH  = 6'b111100;
    localparam logic [5:0] C_FREEZE = 6'b000010;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.XLEN(32)) bus  ();
    hazard_ctrl_if #(.XLEN(32)) bus2 ();

    hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(1), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus)
    );

    hazard_ctrl #(.FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(3), .XLEN(32)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .hz    (bus2)
    );

    // {pc_write, if_id_write, if_id_flush, id_flush, ex_mem_stall, pc_sel}
    function automatic logic [5:0] ctl1();
        return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_flush,
                bus.ex_mem_stall, bus.pc_sel};
    endfunction

    function automatic logic [5:0] ctl2();
        return {bus2.pc_write, bus2.if_id_write, bus2.if_id_flush, bus2.id_flush,
                bus2.ex_mem_stall, bus2.pc_sel};
    endfunction

    task automatic idle();
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_uses_rs2 = 1'b0;
        bus.ex_rd = 5'd0; bus.ex_mem_read = 1'b0; bus.ex_branch_taken = 1'b0;
        bus.ex_jal = 1'b0; bus.ex_jalr = 1'b0; bus.ex_target = 32'd0;
        bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
        bus2.id_rs1 = 5'd0; bus2.id_rs2 = 5'd0; bus2.id_uses_rs2 = 1'b0;
        bus2.ex_rd = 5'd0; bus2.ex_mem_read = 1'b0; bus2.ex_branch_taken = 1'b0;
        bus2.ex_jal = 1'b0; bus2.ex_jalr = 1'b0; bus2.ex_target = 32'd0;
        bus2.dmem_req = 1'b0; bus2.dmem_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst2_n = 1'b0;
        idle();
        bus.ex_jal = 1'b1; bus.ex_target = 32'hDEAD_BEEF; bus.dmem_req = 1'b1;
        #2;
        total++;
        if (ctl1() !== C_RESET) begin
            bad++; $display("FAIL reset_ctl: got %b want %b", ctl1(), C_RESET);
        end
        total++;
        if (bus.pc_target !== 32'd0) begin
            bad++; $display("FAIL reset_target: got %h want %h", bus.pc_target, 32'd0);
        end
        step(); step();
        rst_n = 1'b1; rst2_n = 1'b1;
        idle();
        #1;
        total++;
        if (ctl1() !== C_IDLE) begin
            bad++; $display("FAIL post_reset_idle: got %b want %b", ctl1(), C_IDLE);
        end
    endtask

    task automatic test_load_use();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
        #1;
        total++;
        if (ctl1() !== C_STALL) begin
            bad++; $display("FAIL load_use_detect: got %b want %b", ctl1(), C_STALL);
        end
        step();
        idle();
        #1;
        total++;
        if (ctl1() !== C_IDLE) begin
            bad++; $display("FAIL load_use_one_cycle: got %b want %b", ctl1(), C_IDLE);
        end
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd3;
        bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b1;
        #1;
        total++;
        if (ctl1() !== C_STALL) begin
            bad++; $display("FAIL load_use_rs2: got %b want %b", ctl1(), C_STALL);
        end
        bus.id_uses_rs2 = 1'b0;
        #1;
        total++;
        if (ctl1() !== C_IDLE) begin
            bad++; $display("FAIL rs2_unused: got %b want %b", ctl1(), C_IDLE);
        end
        step();
        idle();
    endtask

    task automatic test_x0_load();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
        #1;
        total++;
        if (ctl1() !== C_IDLE) begin
            bad++; $display("FAIL x0_no_stall: got %b want %b", ctl1(), C_IDLE);
        end
        step();
        idle();
    endtask

    task automatic test_redirect();
        bus.ex_jal = 1'b1; bus.ex_target = 32'h0000_0040;
        #1;
        total++;
        if (ctl1() !== C_REDIR) begin
            bad++; $display("FAIL redirect_detect: got %b want %b", ctl1(), C_REDIR);
        end
        total++;
        if (bus.pc_target !== 32'h0000_0040) begin
            bad++; $display("FAIL redirect_target: got %h want %h", bus.pc_target, 32'h40);
        end
        step();
        idle();
        bus.ex_branch_taken = 1'b1; bus.ex_target = 32'h0000_0080;
        #1;
        total++;
        if (ctl1() !== C_FLUSH) begin
            bad++; $display("FAIL redirect_second_flush: got %b want %b", ctl1(), C_FLUSH);
        end
        step();
        idle();
        #1;
        total++;
        if (ctl1() !== C_IDLE) begin
            bad++; $display("FAIL redirect_done: got %b want %b", ctl1(), C_IDLE);
        end
    endtask

    task automatic test_mem_wait_redirect();
        bus.ex_jalr = 1'b1; bus.ex_target = 32'h0000_0100;
        step();
        idle();
        bus.dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ctl1() !== C_FREEZE) begin
                bad++; $display("FAIL mwait_freeze_%0d: got %b want %b", i, ctl1(), C_FREEZE);
            end
            step();
        end
        bus.dmem_ready = 1'b1;
        #1;
        total++;
        if (ctl1() !== C_FLUSH) begin
            bad++; $display("FAIL mwait_resume_flush: got %b want %b", ctl1(), C_FLUSH);
        end
        step();
        idle();
        #1;
        total++;
        if (ctl1() !== C_IDLE) begin
            bad++; $display("FAIL mwait_flush_done: got %b want %b", ctl1(), C_IDLE);
        end
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b1;
        #1;
        total++;
        if (ctl1() !== C_IDLE) begin
            bad++; $display("FAIL ready_same_cycle: got %b want %b", ctl1(), C_IDLE);
        end
        step();
        idle();
    endtask

    task automatic test_priority();
        bus.dmem_req = 1'b1; bus.ex_branch_taken = 1'b1; bus.ex_target = 32'h0000_0200;
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd4; bus.id_rs1 = 5'd4;
        #1;
        total++;
        if (ctl1() !== C_FREEZE) begin
            bad++; $display("FAIL prio_freeze: got %b want %b", ctl1(), C_FREEZE);
        end
        step();
        bus.dmem_ready = 1'b1;
        #1;
        total++;
        if (ctl1() !== C_REDIR) begin
            bad++; $display("FAIL prio_redirect: got %b want %b", ctl1(), C_REDIR);
        end
        total++;
        if (bus.pc_target !== 32'h0000_0200) begin
            bad++; $display("FAIL prio_target: got %h want %h", bus.pc_target, 32'h200);
        end
        step();
        idle();
        #1;
        total++;
        if (ctl1() !== C_FLUSH) begin
            bad++; $display("FAIL prio_flush2: got %b want %b", ctl1(), C_FLUSH);
        end
        step();
        #1;
        total++;
        if (ctl1() !== C_IDLE) begin
            bad++; $display("FAIL prio_done: got %b want %b", ctl1(), C_IDLE);
        end
    endtask

    task automatic test_long_stall_abandon();
        bus2.ex_mem_read = 1'b1; bus2.ex_rd = 5'd9; bus2.id_rs2 = 5'd9; bus2.id_uses_rs2 = 1'b1;
        step();
        idle();
        #1;
        total++;
        if (ctl2() !== C_STALL) begin
            bad++; $display("FAIL long_stall_hold: got %b want %b", ctl2(), C_STALL);
        end
        bus2.ex_jalr = 1'b1; bus2.ex_target = 32'h0000_0300;
        #1;
        total++;
        if (ctl2() !== C_REDIR || bus2.pc_target !== 32'h0000_0300) begin
            bad++; $display("FAIL stall_abandon: got %b/%h want %b/%h",
                            ctl2(), bus2.pc_target, C_REDIR, 32'h300);
        end
        step();
        idle();
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (ctl2() !== C_FLUSH) begin
                bad++; $display("FAIL flush3_cycle_%0d: got %b want %b", i, ctl2(), C_FLUSH);
            end
            step();
        end
        #1;
        total++;
        if (ctl2() !== C_IDLE) begin
            bad++; $display("FAIL flush3_done: got %b want %b", ctl2(), C_IDLE);
        end
    endtask

    task automatic test_reset_mid_stall();
        bus2.ex_mem_read = 1'b1; bus2.ex_rd = 5'd12; bus2.id_rs1 = 5'd12;
        step();
        idle();
        step();
        #1;
        total++;
        if (ctl2() !== C_STALL) begin
            bad++; $display("FAIL pre_reset_stall: got %b want %b", ctl2(), C_STALL);
        end
        rst2_n = 1'b0;
        #1;
        total++;
        if (ctl2() !== C_RESET) begin
            bad++; $display("FAIL reset_mid_stall: got %b want %b", ctl2(), C_RESET);
        end
        step();
        rst2_n = 1'b1;
        #1;
        total++;
        if (ctl2() !== C_IDLE) begin
            bad++; $display("FAIL after_mid_reset: got %b want %b", ctl2(), C_IDLE);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0_load();
        test_redirect();
        test_mem_wait_redirect();
        test_priority();
        test_long_stall_abandon();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
